// File: rtl/booth_dot_accum.sv
// Saturating dot-product accumulator fed by a stream of signed 16-bit Booth products.
// Each frame ends on a product flagged last. The frame's result is held in registers until downstream accepts it.
module booth_dot_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      prod,
    input  logic             prod_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_sat,
    output logic [CNT_W-1:0] res_count,
    output logic             dbg_state_o
);

    // Handshake: a product moves when prod_valid && prod_ready at a rising edge.
    // A result moves when res_valid && res_ready at a rising edge.
    // ACC only takes products and DONE only offers a result, so the two never overlap.
    typedef enum logic {
        S_ACC  = 1'b0,
        S_DONE = 1'b1
    } state_e;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] res_data_q, res_data_d;
    logic             res_sat_q, res_sat_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;

    logic [ACC_W:0]   sum;
    logic             ovf_pos, ovf_neg;
    logic [ACC_W-1:0] acc_upd;
    logic             sat_upd;
    logic [CNT_W-1:0] cnt_upd;

    // One guard bit above ACC_W. When the top two bits differ, the sum has left the representable range.
    assign sum     = {{(ACC_W-15){prod[15]}}, prod} + {acc_q[ACC_W-1], acc_q};
    assign ovf_pos = ~sum[ACC_W] & sum[ACC_W-1];
    assign ovf_neg = sum[ACC_W] & ~sum[ACC_W-1];
    assign acc_upd = ovf_pos ? ACC_MAX : (ovf_neg ? ACC_MIN : sum[ACC_W-1:0]);
    assign sat_upd = sat_q | ovf_pos | ovf_neg;
    assign cnt_upd = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_sat_d   = res_sat_q;
        res_count_d = res_count_q;
        prod_ready  = 1'b0;
        res_valid   = 1'b0;
        case (state_q)
            S_ACC: begin
                prod_ready = 1'b1;
                if (prod_valid) begin
                    if (prod_last) begin
                        // Publish the frame including this product and start the next frame from zero.
                        state_d     = S_DONE;
                        res_data_d  = acc_upd;
                        res_sat_d   = sat_upd;
                        res_count_d = cnt_upd;
                        acc_d       = '0;
                        sat_d       = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        acc_d = acc_upd;
                        sat_d = sat_upd;
                        cnt_d = cnt_upd;
                    end
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_sat_q   <= 1'b0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_sat_q   <= res_sat_d;
            res_count_q <= res_count_d;
        end
    end

    assign res_data    = res_data_q;
    assign res_sat     = res_sat_q;
    assign res_count   = res_count_q;
    assign dbg_state_o = (state_q == S_DONE);

endmodule

// File: tb/tb_booth_dot_accum.sv
// Randomized and directed bench for booth_dot_accum at ACC_W=24 and CNT_W=8.
// Expected frame results come from a plain-integer saturating-sum model.
module tb_booth_dot_accum;

    logic        clk;
    logic        rst;
    logic        prod_valid;
    logic        prod_ready;
    logic [15:0] prod;
    logic        prod_last;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_data;
    logic        res_sat;
    logic [7:0]  res_count;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    longint      m_acc = 0;
    logic        m_sat = 1'b0;
    int          m_cnt = 0;
    logic [23:0] exp_q[$];
    logic        exp_sat_q[$];
    logic [7:0]  exp_cnt_q[$];

    booth_dot_accum #(.ACC_W(24), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .prod_valid  (prod_valid),
        .prod_ready  (prod_ready),
        .prod        (prod),
        .prod_last   (prod_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_sat     (res_sat),
        .res_count   (res_count),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_acc = 0;
        m_sat = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_add(input int p, input bit last);
        m_acc = m_acc + p;
        if (m_acc > 64'sd8388607) begin
            m_acc = 8388607;
            m_sat = 1'b1;
        end else if (m_acc < -64'sd8388608) begin
            m_acc = -8388608;
            m_sat = 1'b1;
        end
        if (m_cnt < 255) m_cnt++;
        if (last) begin
            exp_q.push_back(m_acc[23:0]);
            exp_sat_q.push_back(m_sat);
            exp_cnt_q.push_back(8'(m_cnt));
            model_clear();
        end
    endtask

    // driver tasks: called at a negedge, return at a negedge
    task automatic idle(input int n);
        prod_valid = 1'b0;
        prod       = 16'($urandom);
        prod_last  = 1'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_prod(input int p, input bit last);
        int budget;
        budget     = 0;
        prod_valid = 1'b1;
        prod       = p[15:0];
        prod_last  = last;
        while (prod_ready !== 1'b1) begin
            @(negedge clk);
            budget++;
            if (budget > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: prod_ready=%b after %0d cycles, required 1", prod_ready, budget);
                prod_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_add(p, last);
        @(negedge clk);
    endtask

    // Called at the negedge right after the last product was accepted.
    task automatic check_result(input string name, input int hold);
        logic [23:0] ed;
        logic        es;
        logic [7:0]  ec;
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: res_valid=%b one cycle after last accept, required 1", name, res_valid);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_model: expected queue empty, required one entry", name);
            return;
        end
        ed = exp_q.pop_front();
        es = exp_sat_q.pop_front();
        ec = exp_cnt_q.pop_front();
        checks++;
        if (res_data !== ed) begin
            errors++;
            $display("FAIL %s_data: got %h, required %h", name, res_data, ed);
        end
        checks++;
        if (res_sat !== es) begin
            errors++;
            $display("FAIL %s_sat: got %b, required %b", name, res_sat, es);
        end
        checks++;
        if (res_count !== ec) begin
            errors++;
            $display("FAIL %s_count: got %0d, required %0d", name, res_count, ec);
        end
        res_ready = 1'b0;
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: res_valid=%b prod_ready=%b, required 0/1", name, res_valid, prod_ready);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        prod_valid = 1'b0;
        prod       = '0;
        prod_last  = 1'b0;
        res_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({prod_ready, res_valid, res_sat, res_count, res_data} !== {1'b1, 1'b0, 1'b0, 8'd0, 24'd0}) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b sat=%b cnt=%0d data=%h, required 1 0 0 0 000000",
                     prod_ready, res_valid, res_sat, res_count, res_data);
        end
    endtask

    task automatic test_basic_frame();
        send_prod(100, 1'b0);
        send_prod(-50, 1'b0);
        send_prod(25, 1'b1);
        check_result("basic", 0);
        checks++;
        if (res_data !== 24'd75 || res_count !== 8'd3 || res_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_direct: data=%0d cnt=%0d sat=%b, required 75 3 0", res_data, res_count, res_sat);
        end
    endtask

    task automatic test_single_min();
        send_prod(-32768, 1'b1);
        check_result("single_min", 1);
        checks++;
        if (res_data !== 24'hFF8000 || res_count !== 8'd1) begin
            errors++;
            $display("FAIL single_min_direct: data=%h cnt=%0d, required ff8000 1", res_data, res_count);
        end
        idle(2);
    endtask

    task automatic test_pos_sat();
        for (int i = 0; i < 300; i++) send_prod(32767, i == 299);
        check_result("pos_sat", 0);
        checks++;
        if (res_data !== 24'd8388607 || res_sat !== 1'b1 || res_count !== 8'd255) begin
            errors++;
            $display("FAIL pos_sat_direct: data=%0d sat=%b cnt=%0d, required 8388607 1 255", res_data, res_sat, res_count);
        end
    endtask

    task automatic test_neg_recover();
        for (int i = 0; i < 257; i++) send_prod(-32768, 1'b0);
        send_prod(32767, 1'b1);
        check_result("neg_recover", 2);
        checks++;
        if (res_data !== 24'h807FFF || res_sat !== 1'b1) begin
            errors++;
            $display("FAIL neg_recover_direct: data=%h sat=%b, required 807fff 1", res_data, res_sat);
        end
    endtask

    task automatic test_back_to_back();
        send_prod(5, 1'b0);
        send_prod(6, 1'b1);
        prod_valid = 1'b1;
        prod       = 16'd123;
        prod_last  = 1'b1;
        res_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (prod_ready !== 1'b0 || res_valid !== 1'b1 ||
                {res_data, res_sat, res_count} !== {exp_q[0], exp_sat_q[0], exp_cnt_q[0]}) begin
                errors++;
                $display("FAIL backpressure_hold: ready=%b valid=%b data=%h sat=%b cnt=%0d, required 0 1 %h %b %0d",
                         prod_ready, res_valid, res_data, res_sat, res_count, exp_q[0], exp_sat_q[0], exp_cnt_q[0]);
            end
            @(negedge clk);
        end
        check_result("backpressure", 0);
        send_prod(123, 1'b1);
        check_result("after_bp", 0);
        checks++;
        if (res_data !== 24'd123 || res_count !== 8'd1) begin
            errors++;
            $display("FAIL after_bp_direct: data=%0d cnt=%0d, required 123 1", res_data, res_count);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_frame();
        send_prod(10, 1'b0);
        send_prod(20, 1'b0);
        idle(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== 1'b0 || prod_ready !== 1'b1 || res_data !== 24'd0 || res_count !== 8'd0) begin
                errors++;
                $display("FAIL reset_mid: valid=%b ready=%b data=%h cnt=%0d, required 0 1 000000 0",
                         res_valid, prod_ready, res_data, res_count);
            end
            @(negedge clk);
        end
        send_prod(7, 1'b1);
        check_result("after_reset", 0);
        checks++;
        if (res_data !== 24'd7 || res_count !== 8'd1 || res_sat !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_direct: data=%0d cnt=%0d sat=%b, required 7 1 0", res_data, res_count, res_sat);
        end
        // Reset while a result is pending discards it.
        send_prod(9, 1'b1);
        idle(0);
        void'(exp_q.pop_front());
        void'(exp_sat_q.pop_front());
        void'(exp_cnt_q.pop_front());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || prod_ready !== 1'b1 || res_data !== 24'd0) begin
            errors++;
            $display("FAIL reset_done: valid=%b ready=%b data=%h, required 0 1 000000", res_valid, prod_ready, res_data);
        end
        idle(1);
    endtask

    task automatic test_random();
        logic [15:0] r;
        int          p;
        int          len;
        for (int f = 0; f < 25; f++) begin
            len = (f == 12) ? 520 : $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if (f == 12) begin
                    p = ($urandom_range(0, 3) != 0) ? 32767 - int'($urandom_range(0, 100))
                                                    : -int'($urandom_range(0, 32768));
                end else begin
                    r = 16'($urandom);
                    p = int'($signed(r));
                end
                send_prod(p, i == len - 1);
            end
            check_result("random", $urandom_range(0, 3));
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_min();
        test_pos_sat();
        test_neg_recover();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_dot_accum.md
Name: booth_dot_accum

Overview:
- Downstream consumer of the 8x8 radix-4 Booth multiplier.
- Accepts a stream of 16-bit signed products over a valid/ready handshake and accumulates them into a wide signed accumulator, with saturation.
- Emits one dot-product result per frame; a frame ends on the product flagged last.
- Sits between the multiplier output and the result bus of the filter/dot-product datapath.

Parameters:
- ACC_W, 24, accumulator and result width in bits (signed); legal range 17..32.
- CNT_W, 8, width of the per-frame product counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- prod_valid  input  1  product on prod is valid.
- prod_ready  output  1  block accepts a product this cycle.
- prod  input  16  signed two's-complement product (multiplier y).
- prod_last  input  1  qualifies prod as the final product of the frame.
- res_valid  output  1  result held on res_* is valid.
- res_ready  input  1  downstream accepts the result.
- res_data  output  ACC_W  signed accumulated sum of the frame.
- res_sat  output  1  saturation occurred at least once during the frame.
- res_count  output  CNT_W  number of products in the frame (saturating).

Behaviour:
- The block is sampled on clk only; no other clock domain.
- A product transfer occurs when prod_valid && prod_ready at a rising edge. A result transfer occurs when res_valid && res_ready.
- State machine, two states:
  - ACC: prod_ready=1, res_valid=0.
  - DONE: prod_ready=0, res_valid=1.
- Transitions:
  - ACC -> ACC on a product transfer with prod_last=0, or on no transfer.
  - ACC -> DONE on a product transfer with prod_last=1.
  - DONE -> ACC on a result transfer.
  - DONE holds while res_ready=0; res_data, res_sat and res_count stay stable.
- Reset: state=ACC, acc=0, sat flag=0, count=0, res_valid=0, res_data=0, res_sat=0, res_count=0, prod_ready=1 in the first cycle after reset is released.
- Arithmetic:
  - prod is sign-extended to ACC_W+1 bits and added to acc, also sign-extended to ACC_W+1 bits.
  - If the sum exceeds 2^(ACC_W-1)-1, acc takes that positive limit; if it is below -2^(ACC_W-1), acc takes that negative limit. In either case the sticky sat flag is set.
  - Otherwise acc takes the sum truncated to ACC_W bits.
  - Saturation is evaluated on every accepted product; a later product may move acc back off the limit, but sat stays set.
- Counter: increments by one per accepted product and holds at 2^CNT_W-1 once reached; saturation of the counter does not set sat.
- Latency: on the accepting edge of a last product, res_data, res_sat and res_count are loaded with the updated values, including that product. res_valid=1 from the next cycle, i.e. one cycle after acceptance.
- On that same edge, acc, sat and count clear to 0, so the next frame starts clean.
- A product with prod_last=1 arriving as the first of a frame is legal: res_count=1 and res_data=sign-extended prod.
- In DONE, prod_valid is ignored and nothing is consumed; upstream must hold its data.
- A result transfer and a new product cannot coincide, because prod_ready=0 in DONE. The first new product is accepted one cycle after the result transfer.
- res_* registers keep their last values after the result transfer until the next frame completes; only res_valid drops.
- Reset asserted mid-frame or in DONE: the partial frame or pending result is discarded, all state returns to reset values, and no res_valid pulse is produced.
- prod and prod_last are don't-care when prod_valid=0.

Test Plan:
- Frame of prods 100, -50, 25 (last), res_ready=1 -> res_valid one cycle after the third accept; res_data=75, res_sat=0, res_count=3.
- Single product -32768 with prod_last=1 -> res_data=-32768 sign-extended (0xFF8000 at ACC_W=24), res_count=1.
- 300 products of 32767, last on the 300th, ACC_W=24 -> res_data=8388607, res_sat=1, res_count=255 (saturated).
- Saturate negative, then add back: 257 x -32768 followed by +32767 (last) -> acc clamps at -8388608, ends at -8355841, res_sat=1.
- Backpressure: result pending with res_ready=0 for 5 cycles while prod_valid=1 -> prod_ready=0 throughout and res_* stable; res_ready=1 -> next product accepted one cycle later and the new frame starts from 0.
- Reset after 2 of 4 products (10, 20), then frame 7 (last) -> no result for the aborted frame; next result res_data=7, res_count=1, res_sat=0.
